// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch, memory-ready handshake, decode and execute.
// Drives one-hot Rin/Rout selects, IRin/MARin/RYin/MDRread and ALUControl.
module control_sequencer #(
  parameter int NSEL    = 32,
  parameter int ALU_W   = 16,
  parameter int REG_W   = 4,
  parameter int IDX_ZHI = 18,
  parameter int IDX_ZLO = 19,
  parameter int IDX_PC  = 20,
  parameter int IDX_MDR = 21,
  parameter int IDX_HI  = 22,
  parameter int IDX_LO  = 23,
  parameter int ALU_INC = 31
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic             stall,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic [NSEL-1:0]  Rin,
  output logic [NSEL-1:0]  Rout,
  output logic             IRin,
  output logic             MARin,
  output logic             RYin,
  output logic             MDRread,
  output logic [ALU_W-1:0] ALUControl,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic             halted
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    C_TWO, C_ONE, C_WIDE, C_NOP, C_HALT, C_ILL
  } cls_t;

  localparam logic [NSEL-1:0] ONE_HOT = NSEL'(1);

  function automatic logic [NSEL-1:0] sel(input int unsigned i);
    return ONE_HOT << i;
  endfunction

  state_t st;
  cls_t   cls;
  state_t eoi;
  logic   is_t;
  logic   act;

  logic [4:0]       op;
  logic [REG_W-1:0] ra;
  logic [REG_W-1:0] rb;
  logic [REG_W-1:0] rc;

  assign op    = ir[31:27];
  assign ra    = ir[23 +: REG_W];
  assign rb    = ir[19 +: REG_W];
  assign rc    = ir[15 +: REG_W];
  assign state = st;
  assign eoi   = run ? S_T0 : S_IDLE;
  assign is_t  = st inside {[S_T0:S_T6]};
  // a stalled T state presents nothing, pulses included
  assign act   = !(is_t && stall);

  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      (op <= 5'd9):                 cls = C_TWO;
      (op == 5'd10 || op == 5'd11): cls = C_ONE;
      (op == 5'd12 || op == 5'd13): cls = C_WIDE;
      (op == 5'd30):                cls = C_NOP;
      (op == 5'd31):                cls = C_HALT;
      default:                      cls = C_ILL;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      st <= S_IDLE;
    end else if (act) begin
      case (st)
        S_IDLE: if (run) st <= S_T0;
        S_T0:   st <= S_T1;
        S_T1:   if (mem_ready) st <= S_T2;
        S_T2:   st <= S_T3;
        S_T3: begin
          case (cls)
            C_HALT:  st <= S_HALT;
            C_NOP,
            C_ILL:   st <= eoi;
            default: st <= S_T4;
          endcase
        end
        S_T4:   st <= (cls == C_ONE) ? eoi : S_T5;
        S_T5:   st <= (cls == C_WIDE) ? S_T6 : eoi;
        S_T6:   st <= eoi;
        S_HALT: st <= S_HALT;
        default: st <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    Rin        = '0;
    Rout       = '0;
    IRin       = 1'b0;
    MARin      = 1'b0;
    RYin       = 1'b0;
    MDRread    = 1'b0;
    ALUControl = '0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    halted     = (st == S_HALT);
    if (act) begin
      case (st)
        S_T0: begin
          Rout       = sel(IDX_PC);
          MARin      = 1'b1;
          Rin        = sel(IDX_ZLO);
          ALUControl = ALU_W'(ALU_INC);
        end
        S_T1: begin
          Rout    = sel(IDX_ZLO);
          Rin     = sel(IDX_PC) | sel(IDX_MDR);
          MDRread = 1'b1;
        end
        S_T2: begin
          Rout = sel(IDX_MDR);
          IRin = 1'b1;
        end
        S_T3: begin
          case (cls)
            C_TWO: begin
              Rout = sel(32'(rb));
              RYin = 1'b1;
            end
            C_ONE: begin
              Rout       = sel(32'(rb));
              ALUControl = ALU_W'(op);
              Rin        = sel(IDX_ZLO);
            end
            C_WIDE: begin
              Rout = sel(32'(ra));
              RYin = 1'b1;
            end
            C_NOP,
            C_HALT:  instr_done = 1'b1;
            default: illegal    = 1'b1;
          endcase
        end
        S_T4: begin
          case (cls)
            C_TWO: begin
              Rout       = sel(32'(rc));
              ALUControl = ALU_W'(op);
              Rin        = sel(IDX_ZLO);
            end
            C_ONE: begin
              Rout       = sel(IDX_ZLO);
              Rin        = sel(32'(ra));
              instr_done = 1'b1;
            end
            C_WIDE: begin
              Rout       = sel(32'(rb));
              ALUControl = ALU_W'(op);
              Rin        = sel(IDX_ZLO) | sel(IDX_ZHI);
            end
            default: ;
          endcase
        end
        S_T5: begin
          Rout = sel(IDX_ZLO);
          if (cls == C_WIDE) begin
            Rin = sel(IDX_LO);
          end else begin
            Rin        = sel(32'(ra));
            instr_done = 1'b1;
          end
        end
        S_T6: begin
          Rout       = sel(IDX_ZHI);
          Rin        = sel(IDX_HI);
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed cycles push expected
// outputs; a negedge monitor pops and compares the full output bundle.
module tb_control_sequencer;

  typedef struct packed {
    logic [3:0]  st;
    logic [31:0] rin;
    logic [31:0] rout;
    logic        irin;
    logic        marin;
    logic        ryin;
    logic        mdr;
    logic [15:0] alu;
    logic        done;
    logic        ill;
    logic        hlt;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic        stall;
  logic        mem_ready;
  logic [31:0] ir;
  logic [31:0] rin_o;
  logic [31:0] rout_o;
  logic        irin_o;
  logic        marin_o;
  logic        ryin_o;
  logic        mdr_o;
  logic [15:0] alu_o;
  logic [3:0]  state_o;
  logic        done_o;
  logic        ill_o;
  logic        hlt_o;

  int checks   = 0;
  int failures = 0;

  exp_t  exp_q[$];
  string tag_q[$];

  control_sequencer dut (
    .clock      (clock),
    .clear      (clear),
    .run        (run),
    .stall      (stall),
    .mem_ready  (mem_ready),
    .ir         (ir),
    .Rin        (rin_o),
    .Rout       (rout_o),
    .IRin       (irin_o),
    .MARin      (marin_o),
    .RYin       (ryin_o),
    .MDRread    (mdr_o),
    .ALUControl (alu_o),
    .state      (state_o),
    .instr_done (done_o),
    .illegal    (ill_o),
    .halted     (hlt_o)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] b(input int i);
    return 32'd1 << i;
  endfunction

  function automatic exp_t ex(
    input int st, input logic [31:0] rin, input logic [31:0] rout,
    input int alu, input logic irin, input logic marin,
    input logic ryin, input logic mdr, input logic done,
    input logic ill, input logic hlt);
    exp_t e;
    e.st    = 4'(st);
    e.rin   = rin;
    e.rout  = rout;
    e.irin  = irin;
    e.marin = marin;
    e.ryin  = ryin;
    e.mdr   = mdr;
    e.alu   = 16'(alu);
    e.done  = done;
    e.ill   = ill;
    e.hlt   = hlt;
    return e;
  endfunction

  function automatic exp_t zero(input int st);
    return ex(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  localparam logic [31:0] NEG  = 32'h5238_0000;
  localparam logic [31:0] ADD  = (32'd0 << 27) | (32'd1 << 23)
                               | (32'd2 << 19) | (32'd3 << 15);
  localparam logic [31:0] MUL  = (32'd12 << 27) | (32'd5 << 23)
                               | (32'd6 << 19);
  localparam logic [31:0] ILL  = 32'd20 << 27;
  localparam logic [31:0] NOP  = 32'd30 << 27;
  localparam logic [31:0] HLT  = 32'd31 << 27;

  exp_t e_t0, e_t1, e_t2;

  task automatic cyc(input logic c, input logic r, input logic s,
                     input logic m, input logic [31:0] i,
                     input string tag, input exp_t e);
    @(posedge clock);
    #1;
    clear     = c;
    run       = r;
    stall     = s;
    mem_ready = m;
    ir        = i;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic fetch(input logic [31:0] i);
    cyc(1, 1, 0, 0, i, "f_t0", e_t0);
    cyc(1, 1, 0, 1, i, "f_t1", e_t1);
    cyc(1, 1, 0, 0, i, "f_t2", e_t2);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  g;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = {state_o, rin_o, rout_o, irin_o, marin_o, ryin_o, mdr_o,
           alu_o, done_o, ill_o, hlt_o};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL %s got st=%0d rin=%h rout=%h ir/mar/ry/mdr=%b%b%b%b alu=%0d d/i/h=%b%b%b need st=%0d rin=%h rout=%h ir/mar/ry/mdr=%b%b%b%b alu=%0d d/i/h=%b%b%b",
          t, g.st, g.rin, g.rout, g.irin, g.marin, g.ryin, g.mdr,
          g.alu, g.done, g.ill, g.hlt, e.st, e.rin, e.rout, e.irin,
          e.marin, e.ryin, e.mdr, e.alu, e.done, e.ill, e.hlt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout queue=%0d", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    e_t0 = ex(1, b(19), b(20), 31, 0, 1, 0, 0, 0, 0, 0);
    e_t1 = ex(2, b(20) | b(21), b(19), 0, 0, 0, 0, 1, 0, 0, 0);
    e_t2 = ex(3, 0, b(21), 0, 1, 0, 0, 0, 0, 0, 0);

    clear     = 1'b0;
    run       = 1'b0;
    stall     = 1'b0;
    mem_ready = 1'b0;
    ir        = '0;
    exp_q.push_back(zero(0));
    tag_q.push_back("reset");
    #12;
    clear = 1'b1;

    // fetch with a 3-cycle memory wait, then a 2-cycle stall in T2
    cyc(1, 1, 0, 0, 0, "idle_run", zero(0));
    cyc(1, 1, 0, 0, 0, "t0", e_t0);
    for (int k = 0; k < 3; k++)
      cyc(1, 1, 0, 0, 0, "t1_wait", e_t1);
    cyc(1, 1, 0, 1, 0, "t1_ready", e_t1);
    cyc(1, 1, 1, 1, NEG, "t2_stall", zero(3));
    cyc(1, 1, 1, 1, NEG, "t2_stall", zero(3));
    cyc(1, 1, 0, 0, NEG, "t2", e_t2);
    cyc(1, 1, 0, 0, NEG, "neg_t3",
        ex(4, b(19), b(7), 10, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 1, 0, 0, NEG, "neg_t4",
        ex(5, b(4), b(19), 0, 0, 0, 0, 0, 1, 0, 0));

    // add R1,R2,R3; stall beats mem_ready in T1
    cyc(1, 1, 0, 0, ADD, "add_t0", e_t0);
    cyc(1, 1, 1, 1, ADD, "t1_stall", zero(2));
    cyc(1, 1, 0, 1, ADD, "t1_resume", e_t1);
    cyc(1, 1, 0, 0, ADD, "add_t2", e_t2);
    cyc(1, 1, 0, 0, ADD, "add_t3",
        ex(4, 0, b(2), 0, 0, 0, 1, 0, 0, 0, 0));
    cyc(1, 1, 0, 0, ADD, "add_t4",
        ex(5, b(19), b(3), 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 1, 0, 0, ADD, "add_t5",
        ex(6, b(1), b(19), 0, 0, 0, 0, 0, 1, 0, 0));

    // mul R5,R6, then drop run so it parks in IDLE
    fetch(MUL);
    cyc(1, 1, 0, 0, MUL, "mul_t3",
        ex(4, 0, b(5), 0, 0, 0, 1, 0, 0, 0, 0));
    cyc(1, 1, 0, 0, MUL, "mul_t4",
        ex(5, b(19) | b(18), b(6), 12, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 1, 0, 0, MUL, "mul_t5",
        ex(6, b(23), b(19), 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, MUL, "mul_t6",
        ex(7, b(22), b(18), 0, 0, 0, 0, 0, 1, 0, 0));
    cyc(1, 0, 0, 0, MUL, "idle_hold", zero(0));
    cyc(1, 1, 0, 0, MUL, "idle_go", zero(0));

    // illegal, nop, halt
    fetch(ILL);
    cyc(1, 1, 0, 0, ILL, "ill_t3",
        ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    fetch(NOP);
    cyc(1, 1, 0, 0, NOP, "nop_t3",
        ex(4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    fetch(HLT);
    cyc(1, 1, 0, 0, HLT, "halt_t3",
        ex(4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    cyc(1, 1, 0, 0, HLT, "halted",
        ex(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(1, 1, 0, 1, HLT, "halted",
        ex(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(0, 1, 0, 0, HLT, "halt_clear", zero(0));

    // asynchronous clear in the middle of T4
    cyc(1, 1, 0, 0, ADD, "idle_run2", zero(0));
    fetch(ADD);
    cyc(1, 1, 0, 0, ADD, "add2_t3",
        ex(4, 0, b(2), 0, 0, 0, 1, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, ADD, "clear_t4", zero(0));
    cyc(1, 0, 0, 0, ADD, "after_clear", zero(0));

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d need=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised hardwired control unit that drives the DataPath control buses: one-hot register-in/out selects, IRin, MARin, RYin, MDRread and ALUControl.
- Replaces hand-sequenced T-state stimulus with a real FSM: instruction fetch, a memory-ready handshake, decode, and execute for one-operand, two-operand and wide (HI/LO) ALU instructions.
- Adds run/stall/halt control and illegal-opcode reporting.

Parameters:
- NSEL, 32, width of Rin/Rout one-hot select buses
- ALU_W, 16, width of ALUControl
- REG_W, 4, register-field width in IR (GPRs occupy bus indices 0..2^REG_W-1)
- IDX_ZHI, 18, bus index of Z-high register
- IDX_ZLO, 19, bus index of Z-low register
- IDX_PC, 20, bus index of PC
- IDX_MDR, 21, bus index of MDR
- IDX_HI, 22, bus index of HI register
- IDX_LO, 23, bus index of LO register
- ALU_INC, 31, ALUControl code for PC+1 during fetch

Ports:
- clock, in, 1: system clock, rising-edge.
- clear, in, 1: asynchronous, active-low reset.
- run, in, 1: start/continue execution.
- stall, in, 1: freeze sequencer.
- mem_ready, in, 1: memory read data valid on Mdatain.
- ir, in, 32: current IR contents from DataPath.
- Rin, out, NSEL: one-hot register load enables.
- Rout, out, NSEL: one-hot bus drive enables.
- IRin, out, 1: IR load.
- MARin, out, 1: MAR load.
- RYin, out, 1: Y load.
- MDRread, out, 1: MDR selects Mdatain.
- ALUControl, out, ALU_W: ALU operation code.
- state, out, 4: current state, for debug.
- instr_done, out, 1: one-cycle pulse on last execute cycle.
- illegal, out, 1: one-cycle pulse on an undefined opcode.
- halted, out, 1: level, sequencer in HALT.

Behaviour:
- IR fields: op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]; only the low REG_W bits of each register field are used.
- ALUControl in execute = zero-extended op.
- Op classes:
  - 0-9: two-operand (TWO).
  - 10-11: one-operand, neg/not (ONE).
  - 12-13: mul/div (WIDE).
  - 30: nop.
  - 31: halt.
  - Anything else: illegal.
- States: IDLE=0, T0..T6=1..7, HALT=8.
- Outputs are decoded combinationally from the registered state plus ir. Every signal not listed for a state is 0.
- Reset: state=IDLE, so all outputs are 0 (halted=0, pulses 0). Reset mid-instruction aborts immediately and no output glitches high.
- IDLE: all 0. Goes to T0 when run=1.
- T0: Rout[PC], MARin, Rin[ZLO], ALUControl=ALU_INC. Goes to T1.
- T1: Rout[ZLO], Rin[PC], MDRread, Rin[MDR].
  - Holds in T1 while mem_ready=0; outputs stay asserted, and the repeated loads are idempotent.
  - Goes to T2 on mem_ready=1.
- T2: Rout[MDR], IRin. Goes to T3; ir is valid from T3 on.
- T3:
  - TWO: Rout[rb], RYin.
  - ONE: Rout[rb], ALUControl=op, Rin[ZLO].
  - WIDE: Rout[ra], RYin.
  - nop: instr_done.
  - halt: instr_done, then HALT.
  - illegal: illegal=1, instr_done=0.
  - nop and illegal return to fetch, the same as end of instruction.
- T4:
  - TWO: Rout[rc], ALUControl=op, Rin[ZLO].
  - ONE: Rout[ZLO], Rin[ra], instr_done.
  - WIDE: Rout[rb], ALUControl=op, Rin[ZLO] and Rin[ZHI].
- T5:
  - TWO: Rout[ZLO], Rin[ra], instr_done.
  - WIDE: Rout[ZLO], Rin[LO].
- T6 (WIDE only): Rout[ZHI], Rin[HI], instr_done.
- End of instruction: goes to T0 if run=1, else IDLE. run is sampled only in IDLE and at end of instruction.
- HALT: all bus outputs 0, halted=1. Sticky until clear.
- stall=1 in any T state:
  - State holds and all outputs are forced to 0, including pulses.
  - Stall wins over mem_ready in the same cycle.
  - Resuming re-presents the held state's outputs for one full cycle.
- Rin/Rout: at most the listed bits set.
  - ra==rb in WIDE still drives a single Rout bit per cycle.
  - In TWO, ra may equal rb or rc: the write happens in T5, after the reads.

Test Plan:
- Fetch with ready: run=1, mem_ready=1.
  - T0 shows Rout[20], MARin, Rin[19], ALUControl=31.
  - T1 shows Rout[19], Rin[20], Rin[21], MDRread.
  - T2 shows Rout[21], IRin.
  - Sequence T0-T1-T2 takes 3 cycles.
- Memory wait: mem_ready low 3 cycles in T1, so T1 lasts 4 cycles with outputs constant. Then stall=1 in T2 holds state for 2 cycles with all outputs 0.
- neg R4,R7 (ir=32'h52380000: op=10, ra=4, rb=7):
  - T3: Rout[7], ALUControl=10, Rin[19].
  - T4: Rout[19], Rin[4], instr_done.
  - Next state T0.
- add R1,R2,R3 (op=0): T3 Rout[2]+RYin; T4 Rout[3]+Rin[19]; T5 Rout[19]+Rin[1]+instr_done.
- mul R5,R6 (op=12): T3 Rout[5]+RYin; T4 Rout[6]+Rin[19]+Rin[18]; T5 Rout[19]+Rin[23]; T6 Rout[18]+Rin[22].
- Control cases:
  - op=20 gives an illegal pulse in T3, then T0.
  - op=31 gives halted=1 and outputs 0, and it persists with run=1.
  - clear low asynchronously in T4 gives state=0 and all outputs 0 immediately.
